// File: rtl/key_event_gen.sv
// Turns the decoder's key level vector into one-cycle press events for W/A/S/D/ENTER,
// with optional auto-repeat on the four direction keys while they are held.
module key_event_gen #(
   parameter logic [8:0]  CODE_UP      = 9'h01D,
   parameter logic [8:0]  CODE_LT      = 9'h01C,
   parameter logic [8:0]  CODE_DW      = 9'h01B,
   parameter logic [8:0]  CODE_RT      = 9'h023,
   parameter logic [8:0]  CODE_CT      = 9'h05A,
   parameter int unsigned REPEAT_DELAY = 50_000_000,
   parameter int unsigned REPEAT_RATE  = 10_000_000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [511:0] key_down,
   input  logic         repeat_en,
   output logic         up_pulse,
   output logic         dw_pulse,
   output logic         lt_pulse,
   output logic         rt_pulse,
   output logic         ct_pulse,
   output logic [4:0]   key_held,
   output logic         any_pulse
);

   // A zero delay or rate behaves as one cycle.
   localparam logic [31:0] DelayLast = (REPEAT_DELAY == 0) ? 32'd0 : REPEAT_DELAY - 32'd1;
   localparam logic [31:0] RateLast  = (REPEAT_RATE == 0)  ? 32'd0 : REPEAT_RATE - 32'd1;

   typedef enum logic [1:0] {StIdle, StWait, StRepeat} rep_state_e;

   // Lane order matches key_held: {up, dw, lt, rt, ct}.
   logic [4:0] raw, held_q, armed_q, pulse_q, pulse_d, press, conflict, rep_ok;
   logic       vert_conf, horiz_conf;

   // Repeat lanes j = 0..3 serve lane bits j+1 (rt, lt, dw, up).
   rep_state_e  state_q [4];
   rep_state_e  state_d [4];
   logic [31:0] cnt_q   [4];
   logic [31:0] cnt_d   [4];
   logic [3:0]  cnt_hit, rep_fire;

   // Only five scan codes are decoded; fold the rest into a sink.
   logic unused_keys;
   assign unused_keys = ^key_down;

   assign raw = {key_down[CODE_UP], key_down[CODE_DW], key_down[CODE_LT],
                 key_down[CODE_RT], key_down[CODE_CT]};

   assign press      = raw & ~held_q & armed_q;
   assign vert_conf  = raw[4] & raw[3];
   assign horiz_conf = raw[2] & raw[1];
   assign conflict   = {vert_conf, vert_conf, horiz_conf, horiz_conf, 1'b0};
   assign rep_ok     = raw & ~conflict & {5{repeat_en}};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         held_q  <= '0;
         armed_q <= '0;
         pulse_q <= '0;
      end else begin
         held_q  <= raw;
         armed_q <= armed_q | ~raw;
         pulse_q <= pulse_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int j = 0; j < 4; j++) begin
            state_q[j] <= StIdle;
            cnt_q[j]   <= '0;
         end
      end else begin
         for (int j = 0; j < 4; j++) begin
            state_q[j] <= state_d[j];
            cnt_q[j]   <= cnt_d[j];
         end
      end
   end

   always_comb begin
      for (int j = 0; j < 4; j++) begin
         state_d[j] = state_q[j];
         cnt_d[j]   = cnt_q[j];
         cnt_hit[j] = 1'b0;
         case (state_q[j])
            StWait:   cnt_hit[j] = (cnt_q[j] == DelayLast);
            StRepeat: cnt_hit[j] = (cnt_q[j] == RateLast);
            default:  cnt_hit[j] = 1'b0;
         endcase
         if (!rep_ok[j+1]) begin
            state_d[j] = StIdle;
            cnt_d[j]   = '0;
         end else begin
            case (state_q[j])
               StIdle: begin
                  if (press[j+1]) begin
                     state_d[j] = StWait;
                     cnt_d[j]   = '0;
                  end
               end
               StWait: begin
                  if (cnt_hit[j]) begin
                     state_d[j] = StRepeat;
                     cnt_d[j]   = '0;
                  end else begin
                     cnt_d[j] = cnt_q[j] + 32'd1;
                  end
               end
               StRepeat: begin
                  cnt_d[j] = cnt_hit[j] ? 32'd0 : cnt_q[j] + 32'd1;
               end
               default: begin
                  state_d[j] = StIdle;
                  cnt_d[j]   = '0;
               end
            endcase
         end
      end
   end

   // Suppressing a fire right after a pulse keeps every lane at most one cycle high.
   always_comb begin
      for (int j = 0; j < 4; j++) begin
         rep_fire[j] = cnt_hit[j] & rep_ok[j+1] & ~pulse_q[j+1];
      end
      pulse_d = press | {rep_fire, 1'b0};
   end

   assign up_pulse  = pulse_q[4];
   assign dw_pulse  = pulse_q[3];
   assign lt_pulse  = pulse_q[2];
   assign rt_pulse  = pulse_q[1];
   assign ct_pulse  = pulse_q[0];
   assign any_pulse = |pulse_q;
   assign key_held  = held_q & armed_q;

endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen with short repeat timing (delay 20, rate 5).
module tb_key_event_gen;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [511:0] key_down;
   logic         repeat_en;
   logic         up_pulse, dw_pulse, lt_pulse, rt_pulse, ct_pulse, any_pulse;
   logic [4:0]   key_held;

   key_event_gen #(
      .REPEAT_DELAY(20),
      .REPEAT_RATE (5)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .key_down (key_down),
      .repeat_en(repeat_en),
      .up_pulse (up_pulse),
      .dw_pulse (dw_pulse),
      .lt_pulse (lt_pulse),
      .rt_pulse (rt_pulse),
      .ct_pulse (ct_pulse),
      .key_held (key_held),
      .any_pulse(any_pulse)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [4:0]  keys;
      int          len;
      logic        repen;
      logic [63:0] e_up, e_dw, e_lt, e_rt, e_ct;
   } vec_t;

   vec_t        tv [10];
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc;
   logic [63:0] m_up, m_dw, m_lt, m_rt, m_ct, m_any;

   function automatic logic [63:0] pm(input int p0, input int p1, input int p2,
                                      input int p3, input int p4);
      logic [63:0] m;
      m = '0;
      if (p0 >= 0) m[p0] = 1'b1;
      if (p1 >= 0) m[p1] = 1'b1;
      if (p2 >= 0) m[p2] = 1'b1;
      if (p3 >= 0) m[p3] = 1'b1;
      if (p4 >= 0) m[p4] = 1'b1;
      return m;
   endfunction

   // Key bits in {up, dw, lt, rt, ct} order; one unrelated code is always held.
   function automatic logic [511:0] kd(input logic [4:0] k);
      logic [511:0] v;
      v = '0;
      v[9'h1FF] = 1'b1;
      v[9'h01D] = k[4];
      v[9'h01B] = k[3];
      v[9'h01C] = k[2];
      v[9'h023] = k[1];
      v[9'h05A] = k[0];
      return v;
   endfunction

   function automatic vec_t mk(input string nm, input logic [4:0] k, input int len,
                               input logic re, input logic [63:0] eu, input logic [63:0] ed,
                               input logic [63:0] el, input logic [63:0] er,
                               input logic [63:0] ec);
      vec_t v;
      v.name = nm; v.keys = k; v.len = len; v.repen = re;
      v.e_up = eu; v.e_dw = ed; v.e_lt = el; v.e_rt = er; v.e_ct = ec;
      return v;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic clear_masks;
      cyc = 0;
      m_up = '0; m_dw = '0; m_lt = '0; m_rt = '0; m_ct = '0; m_any = '0;
   endtask

   // Advance one cycle and record the outputs of the new cycle.
   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
      if (cyc < 64) begin
         m_up[cyc] = up_pulse; m_dw[cyc] = dw_pulse; m_lt[cyc] = lt_pulse;
         m_rt[cyc] = rt_pulse; m_ct[cyc] = ct_pulse; m_any[cyc] = any_pulse;
      end
   endtask

   task automatic check_masks(input string nm, input logic [63:0] eu, input logic [63:0] ed,
                              input logic [63:0] el, input logic [63:0] er,
                              input logic [63:0] ec);
      check({nm, ".up"}, m_up, eu);
      check({nm, ".dw"}, m_dw, ed);
      check({nm, ".lt"}, m_lt, el);
      check({nm, ".rt"}, m_rt, er);
      check({nm, ".ct"}, m_ct, ec);
      check({nm, ".any"}, m_any, eu | ed | el | er | ec);
   endtask

   initial begin
      logic [63:0] z;
      logic [63:0] p1;
      z  = '0;
      p1 = pm(1, -1, -1, -1, -1);

      tv[0] = mk("w_hold8_norep",  5'b10000,  8, 1'b0, p1, z, z, z, z);
      tv[1] = mk("w_hold40_rep",   5'b10000, 40, 1'b1, pm(1, 21, 26, 31, 36), z, z, z, z);
      tv[2] = mk("w_hold40_norep", 5'b10000, 40, 1'b0, p1, z, z, z, z);
      tv[3] = mk("ct_hold60_rep",  5'b00001, 60, 1'b1, z, z, z, z, p1);
      tv[4] = mk("ws_conflict",    5'b11000, 40, 1'b1, p1, p1, z, z, z);
      tv[5] = mk("a_hold30_rep",   5'b00100, 30, 1'b1, z, z, pm(1, 21, 26, -1, -1), z, z);
      tv[6] = mk("d_hold24_rep",   5'b00010, 24, 1'b1, z, z, z, pm(1, 21, -1, -1, -1), z);
      tv[7] = mk("ad_conflict",    5'b00110, 40, 1'b1, z, z, p1, p1, z);
      tv[8] = mk("wa_hold30_rep",  5'b10100, 30, 1'b1, pm(1, 21, 26, -1, -1), z,
                 pm(1, 21, 26, -1, -1), z, z);
      tv[9] = mk("s_hold1",        5'b01000,  1, 1'b1, z, p1, z, z, z);

      key_down  = kd(5'b11111);
      repeat_en = 1'b1;
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst.pulses", 64'({up_pulse, dw_pulse, lt_pulse, rt_pulse, ct_pulse}), z);
      check("rst.key_held", 64'(key_held), z);
      check("rst.any", 64'(any_pulse), z);

      // Keys held through reset release stay silent until released.
      rst = 1'b1;
      clear_masks();
      repeat (6) tick();
      check_masks("held_thru_rst", z, z, z, z, z);
      check("held_thru_rst.key_held", 64'(key_held), z);
      key_down = kd(5'b00000);
      repeat (3) tick();

      for (int i = 0; i < 10; i++) begin
         clear_masks();
         for (int c = 0; c < 63; c++) begin
            key_down  = (c < tv[i].len) ? kd(tv[i].keys) : kd(5'b00000);
            repeat_en = tv[i].repen;
            tick();
            if (cyc == 1) check({tv[i].name, ".held_on"}, 64'(key_held), 64'(tv[i].keys));
            if (cyc == tv[i].len + 1) check({tv[i].name, ".held_off"}, 64'(key_held), z);
         end
         check_masks(tv[i].name, tv[i].e_up, tv[i].e_dw, tv[i].e_lt, tv[i].e_rt, tv[i].e_ct);
      end

      // W+S together, then release S with W still held: no further events.
      repeat_en = 1'b1;
      clear_masks();
      for (int c = 0; c < 50; c++) begin
         key_down = (c < 20) ? kd(5'b11000) : (c < 40) ? kd(5'b10000) : kd(5'b00000);
         tick();
      end
      check_masks("ws_release_s", p1, p1, z, z, z);

      // Glitch 1,0,1 on A gives two separate presses.
      clear_masks();
      for (int c = 0; c < 15; c++) begin
         key_down = (c == 0 || c == 2) ? kd(5'b00100) : kd(5'b00000);
         tick();
      end
      check_masks("a_glitch", z, z, pm(1, 3, -1, -1, -1), z, z);

      // Dropping repeat_en during the delay cancels pending repeats.
      clear_masks();
      for (int c = 0; c < 50; c++) begin
         key_down  = (c < 40) ? kd(5'b10000) : kd(5'b00000);
         repeat_en = (c < 15);
         tick();
      end
      check_masks("repen_drop", p1, z, z, z, z);
      repeat_en = 1'b1;

      // Reset in the cycle a repeat is due (cycle 30 -> would pulse at 31).
      clear_masks();
      key_down = kd(5'b00010);
      repeat (30) tick();
      rst = 1'b0;
      #1;
      check("rst_async.key_held", 64'(key_held), z);
      repeat (3) tick();
      rst = 1'b1;
      repeat (20) tick();
      check("rst_mid.key_held", 64'(key_held), z);
      check_masks("rst_mid_repeat", z, z, z, pm(1, 21, 26, -1, -1), z);

      clear_masks();
      key_down = kd(5'b00000);
      repeat (3) tick();
      key_down = kd(5'b00010);
      repeat (4) tick();
      key_down = kd(5'b00000);
      repeat (6) tick();
      check_masks("d_repress", z, z, z, pm(4, -1, -1, -1, -1), z);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
